// File: rtl/coll_sum_accum.sv
// Streaming frame accumulator feeding adder_32bit: reduces a frame of unsigned
// 32-bit terms to a sum, sticky overflow, term count and a threshold hit flag.
module adder_32bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout
);
  logic [32:0] carry;

  assign carry[0] = Cin;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_fa
      assign S[gi]         = A[gi] ^ B[gi] ^ carry[gi];
      assign carry[gi + 1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
    end
  endgenerate

  assign Cout = carry[32];
endmodule

module coll_sum_accum #(
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  input  logic [31:0]      thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_ovf,
  output logic             out_hit,
  output logic [CNT_W-1:0] out_count
);
  typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

  state_t           state_reg;
  logic [31:0]      acc_reg;
  logic             ovf_reg;
  logic             hit_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [31:0] nsum;
  logic        cout;
  logic        ovf_next;
  logic        closing;

  adder_32bit u_adder (
    .A    (acc_reg),
    .B    (in_data),
    .Cin  (1'b0),
    .S    (nsum),
    .Cout (cout)
  );

  assign ovf_next = ovf_reg | cout;
  assign closing  = in_last || (cnt_reg == CNT_W'(MAX_TERMS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ACC;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      hit_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else if (clr) begin
      // Abort wins over any beat or result handshake in the same cycle.
      state_reg <= ACC;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      hit_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ACC: begin
          if (in_valid) begin
            acc_reg <= nsum;
            ovf_reg <= ovf_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (closing) begin
              // Any wrap in the frame invalidates the sum, so no hit.
              hit_reg   <= !ovf_next && (nsum < thresh);
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= ACC;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            hit_reg   <= 1'b0;
            cnt_reg   <= '0;
          end
        end
        default: state_reg <= ACC;
      endcase
    end
  end

  assign in_ready  = (state_reg == ACC);
  assign out_valid = (state_reg == DONE);
  assign out_sum   = acc_reg;
  assign out_ovf   = ovf_reg;
  assign out_hit   = hit_reg;
  assign out_count = cnt_reg;
endmodule

// File: tb/tb_coll_sum_accum.sv
// Directed bench for coll_sum_accum: reset, basic, overflow, auto-close,
// clear and threshold-boundary frames with hand-computed expectations.
module tb_coll_sum_accum;
  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] thresh;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_ovf;
  logic        out_hit;
  logic [7:0]  out_count;

  int n_cmp;
  int n_err;

  coll_sum_accum #(.MAX_TERMS(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .thresh    (thresh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_hit   (out_hit),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents one term for exactly one rising edge; called and returns at a negedge.
  task automatic send(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ack_ov"}, 32'(out_valid), 32'd0);
    chk({tag, "_ack_ir"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    thresh    = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_ir", 32'(in_ready), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_sum", out_sum, 32'd0);
    chk("rst_cnt", 32'(out_count), 32'd0);
    rst_n = 1'b1;
    step();

    // Asynchronous reset mid-frame
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b0);
    chk("mid_sum", out_sum, 32'd6);
    chk("mid_cnt", 32'(out_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum", out_sum, 32'd0);
    chk("arst_cnt", 32'(out_count), 32'd0);
    chk("arst_ovf", 32'(out_ovf), 32'd0);
    chk("arst_hit", 32'(out_hit), 32'd0);
    chk("arst_ov", 32'(out_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rel_ir", 32'(in_ready), 32'd1);

    // Basic frame 10+20+30 against 100, then stall
    thresh = 32'd100;
    send(32'd10, 1'b0);
    send(32'd20, 1'b0);
    send(32'd30, 1'b1);
    chk("bas_ov", 32'(out_valid), 32'd1);
    chk("bas_ir", 32'(in_ready), 32'd0);
    chk("bas_sum", out_sum, 32'd60);
    chk("bas_cnt", 32'(out_count), 32'd3);
    chk("bas_hit", 32'(out_hit), 32'd1);
    chk("bas_ovf", 32'(out_ovf), 32'd0);
    thresh = 32'd0;
    in_valid = 1'b1;
    in_data  = 32'd99;
    repeat (4) step();
    in_valid = 1'b0;
    chk("stall_ov", 32'(out_valid), 32'd1);
    chk("stall_sum", out_sum, 32'd60);
    chk("stall_cnt", 32'(out_count), 32'd3);
    chk("stall_hit", 32'(out_hit), 32'd1);
    ack("bas");
    chk("bas_clr_sum", out_sum, 32'd0);

    // Overflow: wrap on the closing beat
    thresh = 32'hFFFF_FFFF;
    send(32'hFFFF_FFF0, 1'b0);
    send(32'h0000_0020, 1'b1);
    chk("ovf_sum", out_sum, 32'h10);
    chk("ovf_ovf", 32'(out_ovf), 32'd1);
    chk("ovf_hit", 32'(out_hit), 32'd0);
    ack("ovf");
    chk("ovf_clr", 32'(out_ovf), 32'd0);

    // Auto-close after 16 terms
    thresh = 32'd1000;
    for (int i = 0; i < 16; i++) begin
      chk("auto_ir", 32'(in_ready), 32'd1);
      send(32'd1, 1'b0);
    end
    chk("auto_ov", 32'(out_valid), 32'd1);
    chk("auto_cnt", 32'(out_count), 32'd16);
    chk("auto_sum", out_sum, 32'd16);
    chk("auto_hit", 32'(out_hit), 32'd1);
    in_valid = 1'b1;
    in_data  = 32'd1;
    step();
    step();
    chk("hold_ir", 32'(in_ready), 32'd0);
    chk("hold_sum", out_sum, 32'd16);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bub_ir", 32'(in_ready), 32'd1);
    chk("bub_ov", 32'(out_valid), 32'd0);
    chk("bub_cnt", 32'(out_count), 32'd0);
    in_last = 1'b1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("next_cnt", 32'(out_count), 32'd1);
    chk("next_sum", out_sum, 32'd1);
    chk("next_ov", 32'(out_valid), 32'd1);
    ack("next");

    // Clear drops the coincident term
    thresh = 32'd100;
    send(32'd5, 1'b0);
    send(32'd5, 1'b0);
    chk("pre_clr_sum", out_sum, 32'd10);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd7;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_sum", out_sum, 32'd0);
    chk("clr_cnt", 32'(out_count), 32'd0);
    chk("clr_ir", 32'(in_ready), 32'd1);
    send(32'd9, 1'b1);
    chk("clr9_sum", out_sum, 32'd9);
    chk("clr9_cnt", 32'(out_count), 32'd1);
    chk("clr9_ov", 32'(out_valid), 32'd1);
    ack("clr9");

    // Threshold boundary
    thresh = 32'd50;
    send(32'd50, 1'b1);
    chk("th50_hit", 32'(out_hit), 32'd0);
    chk("th50_sum", out_sum, 32'd50);
    ack("th50");
    thresh = 32'd51;
    send(32'd50, 1'b1);
    chk("th51_hit", 32'(out_hit), 32'd1);
    ack("th51");
    thresh = 32'd0;
    send(32'd0, 1'b1);
    chk("th0_hit", 32'(out_hit), 32'd0);
    chk("th0_ov", 32'(out_valid), 32'd1);
    ack("th0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/coll_sum_accum.md
# coll_sum_accum

Streaming accumulator that sits directly upstream of `adder_32bit` in the collision-detect datapath. It owns the running-sum register, drives `adder_32bit` with (running sum, incoming term, Cin=0), and captures its `S`/`Cout` every accepted beat. A frame of unsigned 32-bit distance terms is reduced to one sum, a sticky overflow bit and a collision hit against a threshold, then handed downstream via valid/ready.

## Interface
- `MAX_TERMS`, default 16: maximum number of terms per frame; the frame closes automatically on the MAX_TERMS-th term. Legal range is 2 to 256.
- `CNT_W`, default 8: width of the term counter and `out_count`. It must satisfy 2^CNT_W > MAX_TERMS.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `clr`, input, 1: synchronous frame abort.
- `in_valid`, input, 1: term present.
- `in_ready`, output, 1: block can accept a term.
- `in_data`, input, 32: unsigned term.
- `in_last`, input, 1: final term of the frame; qualified by `in_valid`.
- `thresh`, input, 32: collision threshold, sampled on the closing beat.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: downstream accepts the result.
- `out_sum`, output, 32: accumulated sum, modulo 2^32.
- `out_ovf`, output, 1: a carry-out occurred at some point during the frame.
- `out_hit`, output, 1: collision flag.
- `out_count`, output, CNT_W: number of terms in the frame.

## Operation
- Two states:
  - ACC: accepting terms; `in_ready`=1, `out_valid`=0.
  - DONE: holding the result; `in_ready`=0, `out_valid`=1.
- Registers: `acc[31:0]`, `ovf`, `cnt[CNT_W-1:0]`, `hit`.
  - `out_sum`=`acc`, `out_ovf`=`ovf`, `out_count`=`cnt`, `out_hit`=`hit`.
- Adder hookup: `adder_32bit` gets A=`acc`, B=`in_data`, Cin=0. Its sum goes to `nsum` and its carry to `cout`.
- Beat = ACC and `in_valid`. On a beat:
  - `acc`<=`nsum`
  - `ovf`<=`ovf` | `cout`
  - `cnt`<=`cnt`+1
- Closing beat: a beat with `in_last`=1, or a beat with `cnt`==MAX_TERMS-1. On a closing beat:
  - the normal beat updates apply;
  - `hit`<=!(`ovf` | `cout`) & (`nsum` < `thresh`), an unsigned compare;
  - state goes to DONE.
- In DONE, `in_*` inputs are ignored. When `out_ready`=1:
  - `acc`, `ovf`, `cnt`, `hit` go to 0;
  - state returns to ACC.
- `clr`=1 takes priority over any beat or handshake. It forces ACC and zeroes `acc`, `ovf`, `cnt`, `hit` on the next edge. A term presented in the same cycle is not accepted and is dropped.
- Outputs stay stable while `out_valid`=1 and `out_ready`=0.
- Reset (`rst_n`=0, at any time including mid-frame):
  - state goes to ACC;
  - `acc`=0, `ovf`=0, `cnt`=0, `hit`=0;
  - hence `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_ovf`=0, `out_hit`=0, `out_count`=0.

## Timing
- Term throughput: 1 term per cycle while in ACC.
- Result latency: closing beat at edge N gives `out_valid`=1 from cycle N+1.
- Result handshake: completes at the first edge where `out_valid` & `out_ready`. `in_ready` returns to 1 in the following cycle, so there is exactly one bubble between frames. `in_ready` never depends combinationally on `out_ready`.
- `out_valid` is registered. There is no combinational path from any input to `out_valid`, `in_ready` or the data outputs.
- Single-term frame (`in_last` on the first beat): `out_count`=1, `out_sum`=`in_data`.
- A wrap with `cout`=1 on the closing beat itself still sets both `ovf` and a forced `hit`=0.
- `thresh`=0 gives `hit`=0 always.

## Test plan
- **Reset:** assert `rst_n`=0 mid-frame after 3 beats → all outputs 0 immediately (asynchronous). After release, `in_ready`=1.
- **Basic frame:** beats 10, 20, 30 with `in_last` on 30, `thresh`=100 → next cycle `out_valid`=1, `out_sum`=60, `out_count`=3, `out_hit`=1, `out_ovf`=0. Then hold `out_ready`=0 for 4 cycles and check outputs are stable.
- **Overflow:** beats 0xFFFFFFF0 then 0x20 (last), `thresh`=0xFFFFFFFF → `out_sum`=0x10, `out_ovf`=1, `out_hit`=0.
- **Auto-close:** MAX_TERMS=16, 16 beats of 1 with `in_last`=0 → `out_valid` after the 16th beat, `out_count`=16, `out_sum`=16. A 17th `in_valid` is held off (`in_ready`=0) until `out_ready`. Then exactly one bubble cycle, and the next frame starts from 0.
- **Clear:** 2 beats of 5, then `clr`=1 together with `in_valid`=1 and `in_data`=7 → term dropped. A new frame of 9 (last) gives `out_sum`=9, `out_count`=1.
- **Threshold boundary:** single-term frame 50 with `thresh`=50 → `out_hit`=0. Same frame with `thresh`=51 → `out_hit`=1.
